// File: rtl/spi_frame_sequencer_pkg.sv
// Shared definitions for the SPI frame sequencer: FSM states, word field
// positions and sticky error bit positions.
package spi_seq_pkg;
    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD,
        ST_XFER,
        ST_CAPTURE,
        ST_RELEASE
    } seq_state_e;

    localparam int SPI_IN_RELEASE_BIT = 8;
    localparam int WR_EOF_BIT         = 8;

    localparam int ERR_TX_OVF  = 0;
    localparam int ERR_RX_OVF  = 1;
    localparam int ERR_LOAD_TO = 2;

    localparam logic [15:0] SPI_RELEASE_WORD = 16'(1) << SPI_IN_RELEASE_BIT;

    function automatic logic [15:0] spi_data_word(input logic [7:0] b);
        return {8'h00, b};
    endfunction
endpackage

// File: rtl/spi_frame_sequencer_if.sv
// CPU-side FIFO access plus the handshake towards the byte-level SPI master.
interface spi_seq_if;
    logic        wr_en;
    logic [8:0]  wr_data;
    logic        rd_en;
    logic [7:0]  rd_data;
    logic        tx_full;
    logic        rx_empty;
    logic        idle;
    logic [2:0]  err;
    logic        clr_err;
    logic        spi_load;
    logic [15:0] spi_in;
    logic        spi_busy;
    logic [15:0] spi_out;

    modport slave (
        input  wr_en, wr_data, rd_en, clr_err, spi_busy, spi_out,
        output rd_data, tx_full, rx_empty, idle, err, spi_load, spi_in
    );
    modport master (
        output wr_en, wr_data, rd_en, clr_err, spi_busy, spi_out,
        input  rd_data, tx_full, rx_empty, idle, err, spi_load, spi_in
    );
endinterface

// File: rtl/spi_frame_sequencer_sync_fifo.sv
// Synchronous FIFO with registered head, full and empty. A pop frees its slot
// for a push in the same cycle, so a full FIFO accepts push+pop together.
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_push,
    input  logic             i_pop,
    input  logic [WIDTH-1:0] i_data,
    output logic [WIDTH-1:0] o_head,
    output logic             o_full,
    output logic             o_empty
);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wr_ptr, r_rd_ptr, w_rd_ptr_n;
    logic [AW:0]      r_cnt, w_cnt_pop, w_cnt_n;
    logic [WIDTH-1:0] r_head;
    logic             r_full, r_empty;
    logic             w_pop, w_push;

    assign w_pop      = i_pop && (r_cnt != '0);
    assign w_push     = i_push && ((r_cnt != FULL_CNT) || w_pop);
    assign w_rd_ptr_n = r_rd_ptr + AW'(w_pop);
    assign w_cnt_pop  = r_cnt - (AW+1)'(w_pop);
    assign w_cnt_n    = w_cnt_pop + (AW+1)'(w_push);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_cnt    <= '0;
            r_head   <= '0;
            r_full   <= 1'b0;
            r_empty  <= 1'b1;
        end else begin
            r_wr_ptr <= r_wr_ptr + AW'(w_push);
            r_rd_ptr <= w_rd_ptr_n;
            r_cnt    <= w_cnt_n;
            r_full   <= (w_cnt_n == FULL_CNT);
            r_empty  <= (w_cnt_n == '0);
            // Head bypasses the array when the pushed word becomes the only entry.
            if (w_cnt_n != '0)
                r_head <= (w_cnt_pop == '0) ? i_data : r_mem[w_rd_ptr_n];
        end
    end

    always_ff @(posedge clk) begin
        if (w_push)
            r_mem[r_wr_ptr] <= i_data;
    end

    assign o_head  = r_head;
    assign o_full  = r_full;
    assign o_empty = r_empty;
endmodule

// File: rtl/spi_frame_sequencer.sv
// Feeds buffered CPU bytes to the SPI master one at a time, releases CS after
// EOF-tagged bytes and collects received bytes into the RX FIFO.
module spi_frame_sequencer
    import spi_seq_pkg::*;
#(
    parameter int DEPTH        = 8,
    parameter int LOAD_TIMEOUT = 64,
    parameter int RELEASE_HOLD = 32
) (
    input logic      CLK_100MHz,
    input logic      reset,
    spi_seq_if.slave bus
);
    localparam int MAXC = (LOAD_TIMEOUT > RELEASE_HOLD) ? LOAD_TIMEOUT : RELEASE_HOLD;
    localparam int CW   = $clog2(MAXC + 1);

    seq_state_e  r_state, w_state_n;
    logic        r_load, w_load_n;
    logic [15:0] r_spi_in, w_spi_in_n;
    logic        r_eof, w_eof_n;
    logic [CW-1:0] r_cnt, w_cnt_n;
    logic [2:0]  r_err, w_err_set;

    logic [8:0]  w_tx_head;
    logic [7:0]  w_rx_head;
    logic        w_tx_full, w_tx_empty, w_tx_push, w_tx_pop;
    logic        w_rx_full, w_rx_empty, w_rx_push;
    logic        w_load_to;
    logic        w_unused;

    assign w_tx_push = bus.wr_en && !w_tx_full;
    assign w_unused  = ^bus.spi_out[15:8];

    sync_fifo #(.WIDTH(9), .DEPTH(DEPTH)) u_tx_fifo (
        .clk(CLK_100MHz), .rst(reset),
        .i_push(w_tx_push), .i_pop(w_tx_pop), .i_data(bus.wr_data),
        .o_head(w_tx_head), .o_full(w_tx_full), .o_empty(w_tx_empty)
    );

    sync_fifo #(.WIDTH(8), .DEPTH(DEPTH)) u_rx_fifo (
        .clk(CLK_100MHz), .rst(reset),
        .i_push(w_rx_push), .i_pop(bus.rd_en), .i_data(bus.spi_out[7:0]),
        .o_head(w_rx_head), .o_full(w_rx_full), .o_empty(w_rx_empty)
    );

    always_comb begin
        w_state_n  = r_state;
        w_load_n   = r_load;
        w_spi_in_n = r_spi_in;
        w_eof_n    = r_eof;
        w_cnt_n    = r_cnt + CW'(1);
        w_tx_pop   = 1'b0;
        w_rx_push  = 1'b0;
        w_load_to  = 1'b0;
        case (r_state)
            ST_IDLE: if (!w_tx_empty) begin
                w_tx_pop   = 1'b1;
                w_spi_in_n = spi_data_word(w_tx_head[7:0]);
                w_eof_n    = w_tx_head[WR_EOF_BIT];
                w_load_n   = 1'b1;
                w_cnt_n    = '0;
                w_state_n  = ST_LOAD;
            end
            ST_LOAD: if (bus.spi_busy) begin
                w_load_n  = 1'b0;
                w_state_n = ST_XFER;
            end else if (r_cnt == CW'(LOAD_TIMEOUT - 1)) begin
                w_load_to = 1'b1;
                w_load_n  = 1'b0;
                w_state_n = ST_IDLE;
            end
            ST_XFER: if (!bus.spi_busy) w_state_n = ST_CAPTURE;
            ST_CAPTURE: begin
                w_rx_push = 1'b1;
                if (r_eof) begin
                    w_spi_in_n = SPI_RELEASE_WORD;
                    w_load_n   = 1'b1;
                    w_cnt_n    = '0;
                    w_state_n  = ST_RELEASE;
                end else begin
                    w_state_n = ST_IDLE;
                end
            end
            // The master never goes busy on a release word; only the hold time matters.
            ST_RELEASE: if (r_cnt == CW'(RELEASE_HOLD - 1)) begin
                w_load_n  = 1'b0;
                w_state_n = ST_IDLE;
            end
            default: w_state_n = ST_IDLE;
        endcase
    end

    always_comb begin
        w_err_set              = '0;
        w_err_set[ERR_TX_OVF]  = bus.wr_en && w_tx_full;
        w_err_set[ERR_RX_OVF]  = w_rx_push && w_rx_full && !bus.rd_en;
        w_err_set[ERR_LOAD_TO] = w_load_to;
    end

    always_ff @(posedge CLK_100MHz) begin
        if (reset) begin
            r_state  <= ST_IDLE;
            r_load   <= 1'b0;
            r_spi_in <= '0;
            r_eof    <= 1'b0;
            r_cnt    <= '0;
            r_err    <= '0;
        end else begin
            r_state  <= w_state_n;
            r_load   <= w_load_n;
            r_spi_in <= w_spi_in_n;
            r_eof    <= w_eof_n;
            r_cnt    <= w_cnt_n;
            r_err    <= (bus.clr_err ? 3'b000 : r_err) | w_err_set;
        end
    end

    assign bus.spi_load = r_load;
    assign bus.spi_in   = r_spi_in;
    assign bus.err      = r_err;
    assign bus.rd_data  = w_rx_head;
    assign bus.tx_full  = w_tx_full;
    assign bus.rx_empty = w_rx_empty;
    assign bus.idle     = (r_state == ST_IDLE) && w_tx_empty;
endmodule

// File: tb/tb_spi_frame_sequencer.sv
// Bench for spi_frame_sequencer: an SPI master stand-in answers loads, a
// queue-based model predicts load words, hold lengths and received bytes.
`timescale 1ns/1ps
module tb_spi_frame_sequencer;
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    spi_seq_if bif();

    spi_frame_sequencer #(.DEPTH(8), .LOAD_TIMEOUT(64), .RELEASE_HOLD(32)) dut (
        .CLK_100MHz(clk),
        .reset     (rst),
        .bus       (bif)
    );

    int n_cmp = 0;
    int n_bad = 0;

    logic [15:0] exp_load[$];
    int          exp_len[$];
    logic [7:0]  exp_rx[$];
    logic [7:0]  resp_q[$];
    logic [2:0]  exp_err;
    int          lat = 3;
    bit          never_busy = 1'b0;
    bit          hold_busy  = 1'b0;
    int          gen = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    // SPI master stand-in: goes busy lat cycles after a data load, returns one byte.
    initial begin : spi_slave
        int my_gen;
        logic [7:0] b;
        bif.spi_busy = 1'b0;
        bif.spi_out  = 16'h0000;
        forever begin
            @(negedge clk);
            if (bif.spi_load === 1'b1 && bif.spi_in[8] === 1'b0 && !never_busy) begin
                my_gen = gen;
                repeat (lat) @(negedge clk);
                b = 8'hEE;
                if (resp_q.size() != 0) b = resp_q.pop_front();
                bif.spi_out  = {8'hA5, b};
                bif.spi_busy = 1'b1;
                repeat (8) @(negedge clk);
                while (hold_busy) @(negedge clk);
                bif.spi_busy = 1'b0;
                if (my_gen == gen) begin
                    if (exp_rx.size() < 8) exp_rx.push_back(b);
                    else exp_err[1] = 1'b1;
                end
            end
        end
    end

    // Every load: word must match the model queue and the high time its expected length.
    bit          prev_load = 1'b0;
    int          load_len  = 0;
    int          len_exp   = 0;
    logic [15:0] word_exp;
    always @(negedge clk) begin
        if (rst) begin
            prev_load = 1'b0;
        end else begin
            if (bif.spi_load && !prev_load) begin
                load_len = 1;
                if (exp_load.size() == 0) begin
                    n_cmp++;
                    n_bad++;
                    $display("FAIL unexpected_load: got spi_in 0x%0h, expected no load at %0t", bif.spi_in, $time);
                end else begin
                    word_exp = exp_load.pop_front();
                    len_exp  = exp_len.pop_front();
                    chk("spi_in", bif.spi_in, word_exp);
                end
            end else if (bif.spi_load) begin
                load_len++;
            end else if (prev_load) begin
                chk("load_len", load_len, len_exp);
            end
            prev_load = bif.spi_load;
        end
    end

    task automatic cpu_write(input logic [8:0] w, input bit ld, input int ld_len);
        if (ld) begin
            exp_load.push_back({8'h00, w[7:0]});
            exp_len.push_back(ld_len);
            if (w[8]) begin
                exp_load.push_back(16'h0100);
                exp_len.push_back(32);
            end
        end
        bif.wr_en   = 1'b1;
        bif.wr_data = w;
        @(negedge clk);
        bif.wr_en   = 1'b0;
    endtask

    task automatic cpu_read(input string name, input bit use_lit, input logic [7:0] lit);
        logic [7:0] v;
        chk({name, "_nonempty"}, bif.rx_empty, 1'b0);
        v = bif.rd_data;
        if (exp_rx.size() == 0) chk({name, "_model_empty"}, 32'(exp_rx.size()), 1);
        else chk({name, "_model"}, v, exp_rx.pop_front());
        if (use_lit) chk({name, "_lit"}, v, lit);
        bif.rd_en = 1'b1;
        @(negedge clk);
        bif.rd_en = 1'b0;
    endtask

    task automatic wait_done(input string tag);
        int k = 0;
        cyc(2);
        while (!(bif.idle && !bif.spi_load && !bif.spi_busy && exp_load.size() == 0) && k < 5000) begin
            cyc(1);
            k++;
        end
        chk({tag, "_done"}, 32'(k < 5000), 1);
    endtask

    task automatic wait_busy(input string tag);
        int k = 0;
        while (bif.spi_busy !== 1'b1 && k < 200) begin
            cyc(1);
            k++;
        end
        chk({tag, "_busy"}, 32'(k < 200), 1);
    endtask

    task automatic pulse_clr();
        bif.clr_err = 1'b1;
        cyc(1);
        bif.clr_err = 1'b0;
        exp_err = 3'b000;
    endtask

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp + 1, n_bad + 1);
        $fatal(1, "watchdog");
    end

    initial begin : main
        logic [7:0] lit3 [3];
        lit3 = '{8'h55, 8'h66, 8'h77};
        rst          = 1'b1;
        bif.wr_en    = 1'b0;
        bif.wr_data  = 9'h000;
        bif.rd_en    = 1'b0;
        bif.clr_err  = 1'b0;
        exp_err      = 3'b000;
        cyc(3);

        chk("rst_spi_load", bif.spi_load, 0);
        chk("rst_spi_in",   bif.spi_in,   0);
        chk("rst_err",      bif.err,      0);
        chk("rst_rd_data",  bif.rd_data,  0);
        chk("rst_tx_full",  bif.tx_full,  0);
        chk("rst_rx_empty", bif.rx_empty, 1);
        chk("rst_idle",     bif.idle,     1);
        rst = 1'b0;
        cyc(2);

        // Three-byte frame ending in EOF, then CS release.
        lat = 3;
        resp_q = '{8'h55, 8'h66, 8'h77};
        cpu_write(9'h02A, 1'b1, 4);
        chk("idle_after_write", bif.idle, 0);
        cpu_write(9'h011, 1'b1, 4);
        cpu_write(9'h1B3, 1'b1, 4);
        wait_done("frame");
        chk("frame_err", bif.err, exp_err);
        for (int i = 0; i < 3; i++) cpu_read("frame_rd", 1'b1, lit3[i]);
        chk("frame_rx_empty", bif.rx_empty, 1);
        bif.rd_en = 1'b1;
        cyc(1);
        bif.rd_en = 1'b0;
        cyc(1);
        chk("empty_read_err", bif.err, 0);

        // TX overflow while the master is stalled busy, plus clr_err races.
        lat = 2;
        hold_busy = 1'b1;
        for (int i = 0; i < 9; i++) resp_q.push_back(8'(8'h10 + i));
        cpu_write(9'h001, 1'b1, 3);
        wait_busy("stall");
        cyc(2);
        for (int i = 0; i < 8; i++) cpu_write(9'(9'h0A0 + i), 1'b1, 3);
        chk("tx_full_after_8", bif.tx_full, 1);
        chk("err_before_ovf", bif.err, 0);
        cpu_write(9'h0A8, 1'b0, 0);
        exp_err[0] = 1'b1;
        chk("err_tx_ovf", bif.err, exp_err);
        pulse_clr();
        chk("err_cleared", bif.err, exp_err);
        bif.wr_en   = 1'b1;
        bif.wr_data = 9'h0A9;
        bif.clr_err = 1'b1;
        cyc(1);
        bif.wr_en   = 1'b0;
        bif.clr_err = 1'b0;
        exp_err[0]  = 1'b1;
        chk("clr_vs_ovf", bif.err, exp_err);
        chk("tx_still_full", bif.tx_full, 1);

        // Drain 9 bytes with no reads: RX keeps 8, overflows on the 9th.
        hold_busy = 1'b0;
        wait_done("drain");
        chk("drain_err", bif.err, exp_err);
        chk("drain_err_lit", bif.err, 3'b011);
        chk("drain_tx_full", bif.tx_full, 0);
        for (int i = 0; i < 8; i++) cpu_read("drain_rd", (i == 0 || i == 7), (i == 0) ? 8'h10 : 8'h17);
        chk("drain_rx_empty", bif.rx_empty, 1);
        pulse_clr();

        // Master never goes busy: each byte times out, the next one is still tried.
        never_busy = 1'b1;
        cpu_write(9'h033, 1'b1, 64);
        cpu_write(9'h044, 1'b1, 64);
        wait_done("timeout");
        exp_err[2] = 1'b1;
        chk("timeout_err", bif.err, exp_err);
        chk("timeout_rx_empty", bif.rx_empty, 1);
        never_busy = 1'b0;
        pulse_clr();
        chk("timeout_cleared", bif.err, 0);

        // Latency extremes: 16 cycles (with EOF) and 1 cycle.
        lat = 16;
        resp_q.push_back(8'hAB);
        cpu_write(9'h1F0, 1'b1, 17);
        wait_done("lat16");
        lat = 1;
        resp_q.push_back(8'hCD);
        cpu_write(9'h00F, 1'b1, 2);
        wait_done("lat1");
        cpu_read("lat16_rd", 1'b1, 8'hAB);
        chk("lat1_rx_pending", bif.rx_empty, 0);

        // Reset while in XFER with a full TX FIFO, pending RX byte and error set.
        lat = 2;
        hold_busy = 1'b1;
        resp_q.push_back(8'h99);
        cpu_write(9'h1C5, 1'b1, 3);
        wait_busy("xfer");
        cyc(2);
        for (int i = 0; i < 9; i++) cpu_write(9'(9'h0B0 + i), 1'b0, 0);
        chk("pre_reset_err", bif.err, 3'b001);
        rst = 1'b1;
        gen++;
        hold_busy = 1'b0;
        exp_load.delete();
        exp_len.delete();
        exp_rx.delete();
        resp_q.delete();
        exp_err = 3'b000;
        cyc(1);
        chk("mid_rst_spi_load", bif.spi_load, 0);
        chk("mid_rst_rx_empty", bif.rx_empty, 1);
        chk("mid_rst_idle",     bif.idle,     1);
        chk("mid_rst_err",      bif.err,      0);
        chk("mid_rst_tx_full",  bif.tx_full,  0);
        rst = 1'b0;
        cyc(12);

        // Normal operation after reset.
        lat = 5;
        resp_q.push_back(8'h3C);
        cpu_write(9'h1E7, 1'b1, 6);
        wait_done("post_rst");
        cpu_read("post_rst_rd", 1'b1, 8'h3C);
        chk("post_rst_err", bif.err, 0);
        chk("loads_left", 32'(exp_load.size()), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
